// File: rtl/cpu_dsack_gen.sv
// cpu_dsack_gen: 68020 bus-termination stage for the fast-RAM / autoconfig block.
//
// Claims a CPU cycle at its start when RAM_ACCESS or Z2_ACCESS is low, waits for the
// RAM controller (plus WAIT_STATES extra ready clocks), then drives DSACK. A claimed
// cycle that is not ready within TIMEOUT clocks is terminated with BERR instead, and
// ERR_COUNT records how often that happened (saturating at 255).
//
// Parameters:
//   WAIT_STATES  extra ready clocks before DSACK asserts (0..15)
//   TIMEOUT      clocks spent waiting before BERR asserts (2..255)
// Ports:
//   CLKCPU      in   CPU clock, all state changes on the rising edge
//   RESET       in   active-low synchronous reset
//   AS20        in   CPU address strobe, active low
//   RAM_ACCESS  in   low = fast-RAM bank decoded for this cycle
//   RAM_READY   in   low = RAM controller has started RAS/CAS
//   Z2_ACCESS   in   low = autoconfig register cycle
//   DSACK       out  {DSACK1,DSACK0}, 00 = 32-bit, 10 = 8-bit, 11 = idle
//   BERR        out  bus error, active low
//   ERR_COUNT   out  saturating timeout count since reset
module cpu_dsack_gen #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RAM_ACCESS,
  input  logic       RAM_READY,
  input  logic       Z2_ACCESS,
  output logic [1:0] DSACK,
  output logic       BERR,
  output logic [7:0] ERR_COUNT
);

  localparam logic [3:0] WaitLimit = 4'(WAIT_STATES);
  localparam logic [7:0] TcntLimit = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;

  state_e      state_q, state_d;
  logic        as_d_q;
  logic        src_ram_q, src_ram_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [1:0]  dsack_q, dsack_d;
  logic        berr_q, berr_d;
  logic [7:0]  err_count_q, err_count_d;

  // Event decode shared by the next-state, counter and output logic. The WAIT events
  // are mutually exclusive in priority order: abort, then timeout, then acknowledge.
  logic cycle_start;
  logic claim;
  logic in_wait;
  logic ready;
  logic abort;
  logic timeout;
  logic ack_now;
  logic release_bus;

  always_comb begin
    cycle_start = ~AS20 & as_d_q;
    claim       = (state_q == StIdle) & cycle_start & (~RAM_ACCESS | ~Z2_ACCESS);
    in_wait     = (state_q == StWait);
    // Autoconfig registers are always ready; only RAM cycles wait on the controller.
    ready       = src_ram_q ? ~RAM_READY : 1'b1;
    abort       = in_wait & AS20;
    timeout     = in_wait & ~AS20 & (tcnt_q == TcntLimit);
    ack_now     = in_wait & ~AS20 & (tcnt_q != TcntLimit) & ready & (wcnt_q == WaitLimit);
    release_bus = ((state_q == StAck) | (state_q == StErr)) & AS20;
  end

  // State register
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q     <= StIdle;
      as_d_q      <= 1'b1;
      src_ram_q   <= 1'b0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      dsack_q     <= 2'b11;
      berr_q      <= 1'b1;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      as_d_q      <= AS20;
      src_ram_q   <= src_ram_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
      dsack_q     <= dsack_d;
      berr_q      <= berr_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (claim) state_d = StWait;
      StWait: begin
        if (abort)        state_d = StIdle;
        else if (timeout) state_d = StErr;
        else if (ack_now) state_d = StAck;
      end
      StAck, StErr: if (release_bus) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Cycle source and wait/timeout counters
  always_comb begin
    src_ram_d = src_ram_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    if (claim) begin
      // RAM wins when both decoders claim the cycle.
      src_ram_d = ~RAM_ACCESS;
      wcnt_d    = '0;
      tcnt_d    = '0;
    end else if (in_wait & ~abort & ~timeout & ~ack_now) begin
      // wcnt only advances on ready clocks, so a RAM_READY dropout pauses it.
      if (ready) wcnt_d = wcnt_q + 4'd1;
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  // Registered bus outputs
  always_comb begin
    dsack_d     = dsack_q;
    berr_d      = berr_q;
    err_count_d = err_count_q;
    if (timeout) begin
      berr_d = 1'b0;
      if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
    end else if (ack_now) begin
      dsack_d = src_ram_q ? 2'b00 : 2'b10;
    end else if (release_bus) begin
      dsack_d = 2'b11;
      berr_d  = 1'b1;
    end
    DSACK     = dsack_q;
    BERR      = berr_q;
    ERR_COUNT = err_count_q;
  end

endmodule

// File: tb/tb_cpu_dsack_gen.sv
module tb_cpu_dsack_gen;

  localparam int NInst = 3;
  localparam int unsigned WsA = 0, ToA = 64;
  localparam int unsigned WsB = 2, ToB = 64;
  localparam int unsigned WsC = 0, ToC = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, as_n, ram_acc, ram_rdy, z2_acc;
  logic [1:0] dsack [NInst];
  logic       berr  [NInst];
  logic [7:0] errc  [NInst];

  cpu_dsack_gen #(.WAIT_STATES(WsA), .TIMEOUT(ToA)) u_ws0 (
    .CLKCPU(clk), .RESET(rst_n), .AS20(as_n), .RAM_ACCESS(ram_acc), .RAM_READY(ram_rdy),
    .Z2_ACCESS(z2_acc), .DSACK(dsack[0]), .BERR(berr[0]), .ERR_COUNT(errc[0]));
  cpu_dsack_gen #(.WAIT_STATES(WsB), .TIMEOUT(ToB)) u_ws2 (
    .CLKCPU(clk), .RESET(rst_n), .AS20(as_n), .RAM_ACCESS(ram_acc), .RAM_READY(ram_rdy),
    .Z2_ACCESS(z2_acc), .DSACK(dsack[1]), .BERR(berr[1]), .ERR_COUNT(errc[1]));
  cpu_dsack_gen #(.WAIT_STATES(WsC), .TIMEOUT(ToC)) u_to8 (
    .CLKCPU(clk), .RESET(rst_n), .AS20(as_n), .RAM_ACCESS(ram_acc), .RAM_READY(ram_rdy),
    .Z2_ACCESS(z2_acc), .DSACK(dsack[2]), .BERR(berr[2]), .ERR_COUNT(errc[2]));

  int checks = 0;
  int failures = 0;

  // Reference model: per instance, whether a claimed cycle is pending, how it ended,
  // how many ready clocks and total clocks it has spent waiting.
  int unsigned m_ws [NInst] = '{WsA, WsB, WsC};
  int unsigned m_to [NInst] = '{ToA, ToB, ToC};
  bit m_pending [NInst];
  int m_outcome [NInst];   // 0 none, 1 acknowledged, 2 bus error
  bit m_is_ram  [NInst];
  int m_ready_clks [NInst];
  int m_clks    [NInst];
  int m_errs    [NInst];
  bit m_as_prev [NInst];

  task automatic model_step(input bit r, input bit a, input bit ra, input bit rr, input bit z2);
    for (int i = 0; i < NInst; i++) begin
      if (!r) begin
        m_pending[i] = 0; m_outcome[i] = 0; m_errs[i] = 0; m_as_prev[i] = 1;
        m_ready_clks[i] = 0; m_clks[i] = 0;
      end else begin
        if (m_outcome[i] != 0) begin
          if (a) m_outcome[i] = 0;
        end else if (m_pending[i]) begin
          bit rdy;
          rdy = m_is_ram[i] ? !rr : 1'b1;
          if (a) begin
            m_pending[i] = 0;
          end else if (m_clks[i] == int'(m_to[i]) - 1) begin
            m_pending[i] = 0; m_outcome[i] = 2;
            if (m_errs[i] < 255) m_errs[i]++;
          end else if (rdy && m_ready_clks[i] == int'(m_ws[i])) begin
            m_pending[i] = 0; m_outcome[i] = 1;
          end else begin
            if (rdy) m_ready_clks[i]++;
            m_clks[i]++;
          end
        end else if (!a && m_as_prev[i] && (!ra || !z2)) begin
          m_pending[i] = 1; m_is_ram[i] = !ra; m_ready_clks[i] = 0; m_clks[i] = 0;
        end
        m_as_prev[i] = a;
      end
    end
  endtask

  function automatic logic [10:0] model_out(int i);
    logic [1:0] d;
    d = (m_outcome[i] == 1) ? (m_is_ram[i] ? 2'b00 : 2'b10) : 2'b11;
    return {d, (m_outcome[i] != 2), 8'(m_errs[i])};
  endfunction

  function automatic logic [10:0] dut_out(int i);
    return {dsack[i], berr[i], errc[i]};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got dsack/berr/errcnt=%b/%b/%0d expected %b/%b/%0d", name,
               act[10:9], act[8], act[7:0], exp[10:9], exp[8], exp[7:0]);
    end
  endtask

  // Drive inputs (at the falling edge), let one rising edge pass, then compare at the
  // next falling edge.
  task automatic cycle(input bit r, input bit a, input bit ra, input bit rr, input bit z2,
                       input bit chk);
    rst_n = r; as_n = a; ram_acc = ra; ram_rdy = rr; z2_acc = z2;
    @(posedge clk);
    model_step(r, a, ra, rr, z2);
    @(negedge clk);
    if (chk) begin
      check("model_ws0", dut_out(0), model_out(0));
      check("model_ws2", dut_out(1), model_out(1));
      check("model_to8", dut_out(2), model_out(2));
    end
  endtask

  typedef struct {
    bit r; bit a; bit ra; bit rr; bit z2;
    logic [1:0] exp_dsack; bit exp_berr;
  } vec_t;

  vec_t tbl [15];
  bit   cur_as;

  initial begin
    rst_n = 1'b0; as_n = 1'b1; ram_acc = 1'b1; ram_rdy = 1'b1; z2_acc = 1'b1;

    // Expected values are for the WAIT_STATES=0 instance.
    tbl[0]  = '{0, 1, 1, 1, 1, 2'b11, 1};  // reset
    tbl[1]  = '{1, 1, 1, 1, 1, 2'b11, 1};
    tbl[2]  = '{1, 0, 0, 0, 1, 2'b11, 1};  // e0: RAM start
    tbl[3]  = '{1, 0, 0, 0, 1, 2'b00, 1};  // e1: acknowledged
    tbl[4]  = '{1, 0, 0, 0, 1, 2'b00, 1};  // held
    tbl[5]  = '{1, 1, 0, 0, 1, 2'b11, 1};  // negated one edge after AS high
    tbl[6]  = '{1, 0, 1, 1, 0, 2'b11, 1};  // Z2 start
    tbl[7]  = '{1, 0, 1, 1, 0, 2'b10, 1};  // 8-bit ack
    tbl[8]  = '{1, 1, 1, 1, 0, 2'b11, 1};
    tbl[9]  = '{1, 0, 0, 0, 0, 2'b11, 1};  // both claim
    tbl[10] = '{1, 0, 0, 0, 0, 2'b00, 1};  // RAM priority
    tbl[11] = '{1, 1, 0, 0, 0, 2'b11, 1};
    tbl[12] = '{1, 0, 1, 1, 1, 2'b11, 1};  // unclaimed start
    tbl[13] = '{1, 0, 0, 0, 1, 2'b11, 1};  // late decode, not a start
    tbl[14] = '{1, 1, 0, 0, 1, 2'b11, 1};

    for (int k = 0; k < 15; k++) begin
      cycle(tbl[k].r, tbl[k].a, tbl[k].ra, tbl[k].rr, tbl[k].z2, 1);
      check($sformatf("table_%0d", k), {dsack[0], berr[0], 8'd0},
            {tbl[k].exp_dsack, tbl[k].exp_berr, 8'd0});
    end
    check("reset_errcnt", dut_out(2), {2'b11, 1'b1, 8'd0});

    // Wait-state stall on WAIT_STATES=2: ready 1 clock, not ready 3, then ready.
    cycle(1, 0, 0, 1, 1, 1);                       // e0
    cycle(1, 0, 0, 0, 1, 1);                       // e1 ready clock 1
    check("stall_ws0_ack", dut_out(0), {2'b00, 1'b1, 8'd0});
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1, 1, 1);
    check("stall_paused", dut_out(1), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 0, 1, 1);                       // ready clock 2
    check("stall_two_ready", dut_out(1), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 0, 1, 1);                       // ready clock 3
    check("stall_ack", dut_out(1), {2'b00, 1'b1, 8'd0});
    cycle(1, 1, 0, 0, 1, 1);
    check("stall_negate", dut_out(1), {2'b11, 1'b1, 8'd0});

    // Abort during WAIT.
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 1, 0, 0, 1, 1);
    check("abort_ws2", dut_out(1), {2'b11, 1'b1, 8'd0});
    cycle(1, 1, 0, 0, 1, 1);
    check("abort_to8", dut_out(2), {2'b11, 1'b1, 8'd0});

    // Back-to-back RAM cycles with one clock of AS high between them.
    cycle(1, 0, 0, 0, 1, 1);
    check("b2b_first_e0", dut_out(0), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 0, 1, 1);
    check("b2b_first_ack", dut_out(0), {2'b00, 1'b1, 8'd0});
    cycle(1, 1, 0, 0, 1, 1);
    check("b2b_gap", dut_out(0), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 0, 1, 1);
    check("b2b_second_e0", dut_out(0), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 0, 1, 1);
    check("b2b_second_ack", dut_out(0), {2'b00, 1'b1, 8'd0});
    cycle(1, 1, 0, 0, 1, 1);

    // Timeout on TIMEOUT=8.
    cycle(1, 0, 0, 1, 1, 1);                       // e0
    for (int k = 1; k <= 7; k++) cycle(1, 0, 0, 1, 1, 1);
    check("timeout_e7", dut_out(2), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 1, 1, 1);                       // e8
    check("timeout_e8", dut_out(2), {2'b11, 1'b0, 8'd1});
    cycle(1, 1, 0, 1, 1, 1);
    check("timeout_release", dut_out(2), {2'b11, 1'b1, 8'd1});

    // 299 more timeouts saturate the counter.
    for (int n = 0; n < 299; n++) begin
      for (int k = 0; k <= 8; k++) cycle(1, 0, 0, 1, 1, 0);
      cycle(1, 1, 0, 1, 1, (n == 298));
    end
    check("saturate_255", dut_out(2), {2'b11, 1'b1, 8'd255});
    for (int k = 0; k <= 8; k++) cycle(1, 0, 0, 1, 1, 1);
    check("saturate_hold", dut_out(2), {2'b11, 1'b0, 8'd255});
    cycle(1, 1, 0, 1, 1, 1);

    // Reset in the middle of a WAIT_STATES=2 cycle.
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    check("rst_mid_ws2", dut_out(1), {2'b11, 1'b1, 8'd0});
    check("rst_mid_errcnt", dut_out(2), {2'b11, 1'b1, 8'd0});
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 0, 1, 1);
      check($sformatf("rst_no_ack_%0d", k), dut_out(1), {2'b11, 1'b1, 8'd0});
    end
    cycle(1, 0, 0, 0, 1, 1);                       // e0
    cycle(1, 0, 0, 0, 1, 1);                       // e1
    cycle(1, 0, 0, 0, 1, 1);                       // e2
    check("rst_new_e2", dut_out(1), {2'b11, 1'b1, 8'd0});
    cycle(1, 0, 0, 0, 1, 1);                       // e3
    check("rst_new_ack", dut_out(1), {2'b00, 1'b1, 8'd0});
    cycle(1, 1, 0, 0, 1, 1);

    // Randomized traffic against the model.
    cur_as = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) < 2) cur_as = ~cur_as;
      cycle(1, cur_as, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
